// File: rtl/alu_result_fifo.sv
// Registered FWFT output FIFO behind the 4-bit ALU: buffers result+flags+select,
// tracks sticky carry/overflow and a saturating count of delivered results.
module alu_result_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_out,
    input  logic [4:0]               in_flags,
    input  logic [1:0]               in_select,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [4:0]               out_flags,
    output logic [1:0]               out_select,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               sticky,
    input  logic                     sticky_clr,
    output logic [CNT_W-1:0]         result_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [4:0]    flags;
        logic [1:0]    sel;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    entry_t          head;

    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is masked while empty so stale array contents never leak out.
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_data   = head.data;
    assign out_flags  = head.flags;
    assign out_select = head.sel;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: in_out, flags: in_flags, sel: in_select};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            sticky     <= 2'b00;
            result_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A push in the clear cycle still records its own carry/overflow.
            sticky <= (sticky_clr ? 2'b00 : sticky) |
                      (push ? {in_flags[4], in_flags[0]} : 2'b00);
            if (pop && result_cnt != {CNT_W{1'b1}})
                result_cnt <= result_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench: stimulus queues expected entries, a negedge monitor checks
// the head, level, status and counters of a default and a CNT_W=2 instance.
module tb_alu_result_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, sticky_clr;
    logic [3:0] in_out;
    logic [4:0] in_flags;
    logic [1:0] in_select;

    logic       in_ready, out_valid;
    logic [3:0] out_data;
    logic [4:0] out_flags;
    logic [1:0] out_select, sticky;
    logic [2:0] level;
    logic [7:0] result_cnt;

    logic       s_in_ready, s_out_valid;
    logic [3:0] s_out_data;
    logic [4:0] s_out_flags;
    logic [1:0] s_out_select, s_sticky;
    logic [2:0] s_level;
    logic [1:0] s_result_cnt;

    alu_result_fifo #(.DW(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_out(in_out), .in_flags(in_flags), .in_select(in_select),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_select(out_select), .level(level),
        .sticky(sticky), .sticky_clr(sticky_clr), .result_cnt(result_cnt));

    alu_result_fifo #(.DW(4), .DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_out(in_out), .in_flags(in_flags), .in_select(in_select),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_flags(s_out_flags), .out_select(s_out_select), .level(s_level),
        .sticky(s_sticky), .sticky_clr(sticky_clr), .result_cnt(s_result_cnt));

    always #5 clk = ~clk;

    // Reference model: a queue of expected entries plus plain counters.
    logic [10:0] sbq[$];
    int          mlevel = 0, mcnt8 = 0, mcnt2 = 0;
    logic [1:0]  msticky = 2'b00;
    bit          p_push = 0, p_pop = 0, p_clr = 0;
    logic [4:0]  p_f = '0;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Commit the handshake decided for the edge that just occurred.
    task automatic apply_pending();
        if (p_pop) begin
            if (mcnt8 < 255) mcnt8++;
            if (mcnt2 < 3)   mcnt2++;
        end
        mlevel  = mlevel + int'(p_push) - int'(p_pop);
        msticky = (p_clr ? 2'b00 : msticky) | (p_push ? {p_f[4], p_f[0]} : 2'b00);
    endtask

    task automatic step(input bit v, input logic [3:0] d, input logic [4:0] f,
                        input logic [1:0] s, input bit ordy, input bit clr);
        @(posedge clk); #1;
        apply_pending();
        in_valid = v; in_out = d; in_flags = f; in_select = s;
        out_ready = ordy; sticky_clr = clr;
        p_push = v && (mlevel < DEPTH);
        p_pop  = ordy && (mlevel > 0);
        p_clr  = clr;
        p_f    = f;
        if (p_push) sbq.push_back({d, f, s});
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 4'($urandom), 5'($urandom), 2'($urandom), ordy, 1'b0);
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++)
            step(1'b1, 4'(base + i), 5'($urandom), 2'($urandom), 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", 32'(level), 32'(mlevel));
            chk("in_ready", 32'(in_ready), 32'(mlevel != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mlevel != 0));
            chk("sticky", 32'(sticky), 32'(msticky));
            chk("result_cnt", 32'(result_cnt), 32'(mcnt8));
            chk("s_level", 32'(s_level), 32'(mlevel));
            chk("s_result_cnt", 32'(s_result_cnt), 32'(mcnt2));
            if (mlevel == 0) begin
                chk("empty_head", 32'({out_data, out_flags, out_select}), 32'(0));
            end else if (sbq.size() > 0) begin
                chk("head", 32'({out_data, out_flags, out_select}), 32'(sbq[0]));
                chk("s_head", 32'({s_out_data, s_out_flags, s_out_select}), 32'(sbq[0]));
            end
            if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_level"}, 32'(level), 32'(0));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        chk({tag, "_head"}, 32'({out_data, out_flags, out_select}), 32'(0));
        chk({tag, "_sticky"}, 32'(sticky), 32'(0));
        chk({tag, "_result_cnt"}, 32'(result_cnt), 32'(0));
        chk({tag, "_s_level"}, 32'(s_level), 32'(0));
        chk({tag, "_s_result_cnt"}, 32'(s_result_cnt), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; sticky_clr = 0;
        in_out = '0; in_flags = '0; in_select = '0;
        #2 check_reset_state("rst");
        #1 rst_n = 1'b1;

        // Single push, visible one cycle later; then drain.
        step(1'b1, 4'h9, 5'b10001, 2'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to full, refused fifth push, then drain in order.
        push_n(4, 1);
        step(1'b1, 4'h5, 5'b00000, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Steady push+pop at level 2 across pointer wrap.
        push_n(2, 6);
        for (int i = 0; i < 6; i++)
            step(1'b1, 4'(8 + i), 5'($urandom), 2'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Full with simultaneous in_valid/out_ready: pop only.
        push_n(4, 12);
        step(1'b1, 4'hF, 5'b11111, 2'd3, 1'b1, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Sticky clear interplay.
        step(1'b1, 4'h1, 5'b10001, 2'd0, 1'b1, 1'b0);
        step(1'b1, 4'h2, 5'b10000, 2'd0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 5'b00000, 2'd0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic with shifting bias to visit full and empty.
        for (int i = 0; i < 400; i++) begin
            bit v, r;
            v = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(v, 4'($urandom), 5'($urandom), 2'($urandom), r, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset mid-stream with three entries held.
        for (int i = 0; i < 6; i++) idle(1'b1);
        push_n(3, 3);
        idle(1'b0);
        @(posedge clk); #1;
        apply_pending();
        in_valid = 1'b1; out_ready = 1'b1; sticky_clr = 1'b0;
        #1 rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check_reset_state("arst");
        sbq.delete();
        mlevel = 0; mcnt8 = 0; mcnt2 = 0; msticky = 2'b00;
        p_push = 0; p_pop = 0; p_clr = 0;
        #1 rst_n = 1'b1;
        step(1'b1, 4'hA, 5'b00001, 2'd2, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
